// File: rtl/cache_pkg.sv
// Shared types and constants for the cache-side memory arbiter.
package cache_pkg;

  localparam logic [2:0] RD_TYPE_WORD = 3'b010;
  localparam logic [2:0] RD_TYPE_LINE = 3'b100;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} rd_state_t;

  typedef enum logic {OWN_I, OWN_D} owner_t;

endpackage

// File: rtl/cache_wr_buffer.sv
// One-entry staging buffer for dcache writebacks, with a line-address
// compare used to hold back dcache reads to a line still being written.
module cache_wr_buffer #(
  parameter int ADDR_W   = 32,
  parameter int LINE_OFF = 4
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       en,
  input  logic                       wr_req,
  input  logic [2:0]                 wr_type,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [3:0]                 wr_wstrb,
  input  logic [127:0]               wr_data,
  output logic                       wr_rdy,
  output logic                       m_wr_req,
  output logic [2:0]                 m_wr_type,
  output logic [ADDR_W-1:0]          m_wr_addr,
  output logic [3:0]                 m_wr_wstrb,
  output logic [127:0]               m_wr_data,
  input  logic                       m_wr_rdy,
  input  logic [ADDR_W-LINE_OFF-1:0] rd_line,
  output logic                       hit_line
);

  logic                 wb_valid_q, wb_valid_d;
  logic [2:0]           wb_type_q, wb_type_d;
  logic [ADDR_W-1:0]    wb_addr_q, wb_addr_d;
  logic [3:0]           wb_wstrb_q, wb_wstrb_d;
  logic [127:0]         wb_data_q, wb_data_d;

  // Capture only when empty and drain only when full, so they are exclusive.
  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_type_d  = wb_type_q;
    wb_addr_d  = wb_addr_q;
    wb_wstrb_d = wb_wstrb_q;
    wb_data_d  = wb_data_q;
    if (en && wr_req && !wb_valid_q) begin
      wb_valid_d = 1'b1;
      wb_type_d  = wr_type;
      wb_addr_d  = wr_addr;
      wb_wstrb_d = wr_wstrb;
      wb_data_d  = wr_data;
    end else if (wb_valid_q && m_wr_rdy) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wb_valid_q <= 1'b0;
      wb_type_q  <= '0;
      wb_addr_q  <= '0;
      wb_wstrb_q <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_type_q  <= wb_type_d;
      wb_addr_q  <= wb_addr_d;
      wb_wstrb_q <= wb_wstrb_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign wr_rdy     = en & ~wb_valid_q;
  assign m_wr_req   = wb_valid_q;
  assign m_wr_type  = wb_type_q;
  assign m_wr_addr  = wb_addr_q;
  assign m_wr_wstrb = wb_wstrb_q;
  assign m_wr_data  = wb_data_q;
  assign hit_line   = wb_valid_q && (rd_line == wb_addr_q[ADDR_W-1:LINE_OFF]);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between icache and dcache: round-robin read
// arbitration with a single outstanding read, plus a one-entry write buffer.
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int LINE_OFF = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              i_rd_req,
  input  logic [2:0]        i_rd_type,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              i_rd_rdy,
  output logic              i_ret_valid,
  output logic              i_ret_last,
  output logic [31:0]       i_ret_data,
  input  logic              d_rd_req,
  input  logic [2:0]        d_rd_type,
  input  logic [ADDR_W-1:0] d_rd_addr,
  output logic              d_rd_rdy,
  output logic              d_ret_valid,
  output logic              d_ret_last,
  output logic [31:0]       d_ret_data,
  input  logic              d_wr_req,
  input  logic [2:0]        d_wr_type,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [3:0]        d_wr_wstrb,
  input  logic [127:0]      d_wr_data,
  output logic              d_wr_rdy,
  output logic              m_rd_req,
  output logic [2:0]        m_rd_type,
  output logic [ADDR_W-1:0] m_rd_addr,
  input  logic              m_rd_rdy,
  input  logic              m_ret_valid,
  input  logic              m_ret_last,
  input  logic [31:0]       m_ret_data,
  output logic              m_wr_req,
  output logic [2:0]        m_wr_type,
  output logic [ADDR_W-1:0] m_wr_addr,
  output logic [3:0]        m_wr_wstrb,
  output logic [127:0]      m_wr_data,
  input  logic              m_wr_rdy
);

  rd_state_t         state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [2:0]        rd_type_q, rd_type_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              last_d_q, last_d_d;
  logic              run_q;
  logic              hit_line;
  logic              i_elig, d_elig;

  // run_q keeps every ready low while reset is held and for the release cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) run_q <= 1'b0;
    else         run_q <= 1'b1;
  end

  cache_wr_buffer #(.ADDR_W(ADDR_W), .LINE_OFF(LINE_OFF)) u_wr_buffer (
    .clock      (clock),
    .resetn     (resetn),
    .en         (run_q),
    .wr_req     (d_wr_req),
    .wr_type    (d_wr_type),
    .wr_addr    (d_wr_addr),
    .wr_wstrb   (d_wr_wstrb),
    .wr_data    (d_wr_data),
    .wr_rdy     (d_wr_rdy),
    .m_wr_req   (m_wr_req),
    .m_wr_type  (m_wr_type),
    .m_wr_addr  (m_wr_addr),
    .m_wr_wstrb (m_wr_wstrb),
    .m_wr_data  (m_wr_data),
    .m_wr_rdy   (m_wr_rdy),
    .rd_line    (d_rd_addr[ADDR_W-1:LINE_OFF]),
    .hit_line   (hit_line)
  );

  assign i_elig = run_q & i_rd_req;
  assign d_elig = run_q & d_rd_req & ~hit_line;

  // On a tie the requester not granted last wins; last_d_q=1 favours icache.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rd_type_d = rd_type_q;
    rd_addr_d = rd_addr_q;
    last_d_d  = last_d_q;
    i_rd_rdy  = 1'b0;
    d_rd_rdy  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_elig && (!d_elig || last_d_q)) begin
          i_rd_rdy  = 1'b1;
          owner_d   = OWN_I;
          rd_type_d = i_rd_type;
          rd_addr_d = i_rd_addr;
          last_d_d  = 1'b0;
          state_d   = REQ;
        end else if (d_elig) begin
          d_rd_rdy  = 1'b1;
          owner_d   = OWN_D;
          rd_type_d = d_rd_type;
          rd_addr_d = d_rd_addr;
          last_d_d  = 1'b1;
          state_d   = REQ;
        end
      end
      REQ:     if (m_rd_rdy) state_d = WAIT;
      WAIT:    if (m_ret_valid && m_ret_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      rd_type_q <= '0;
      rd_addr_q <= '0;
      last_d_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rd_type_q <= rd_type_d;
      rd_addr_q <= rd_addr_d;
      last_d_q  <= last_d_d;
    end
  end

  assign m_rd_req    = (state_q == REQ);
  assign m_rd_type   = rd_type_q;
  assign m_rd_addr   = rd_addr_q;
  assign i_ret_valid = (state_q == WAIT) && (owner_q == OWN_I) && m_ret_valid;
  assign i_ret_last  = (state_q == WAIT) && (owner_q == OWN_I) && m_ret_last;
  assign d_ret_valid = (state_q == WAIT) && (owner_q == OWN_D) && m_ret_valid;
  assign d_ret_last  = (state_q == WAIT) && (owner_q == OWN_D) && m_ret_last;
  assign i_ret_data  = m_ret_data;
  assign d_ret_data  = m_ret_data;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: stimulus pushes expected bridge
// requests and return beats; a negedge monitor pops and compares them.
module tb_cache_mem_arbiter;
  import cache_pkg::*;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         i_rd_req = 0, d_rd_req = 0, d_wr_req = 0;
  logic [2:0]   i_rd_type = 0, d_rd_type = 0, d_wr_type = 0;
  logic [31:0]  i_rd_addr = 0, d_rd_addr = 0, d_wr_addr = 0;
  logic [3:0]   d_wr_wstrb = 0;
  logic [127:0] d_wr_data = 0;
  logic         m_rd_rdy = 0, m_ret_valid = 0, m_ret_last = 0, m_wr_rdy = 0;
  logic [31:0]  m_ret_data = 0;
  logic         i_rd_rdy, i_ret_valid, i_ret_last, d_rd_rdy, d_ret_valid, d_ret_last;
  logic         d_wr_rdy, m_rd_req, m_wr_req;
  logic [31:0]  i_ret_data, d_ret_data, m_rd_addr, m_wr_addr;
  logic [2:0]   m_rd_type, m_wr_type;
  logic [3:0]   m_wr_wstrb;
  logic [127:0] m_wr_data;

  typedef struct packed {logic [31:0] data; logic last;} beat_t;
  beat_t        exp_i[$];
  beat_t        exp_d[$];
  logic [34:0]  exp_rd[$];
  logic [166:0] exp_wr[$];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  cache_mem_arbiter #(.ADDR_W(32), .LINE_OFF(4)) dut (
    .clock(clock), .resetn(resetn),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
    .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
    .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
    .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
    .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
    .m_rd_req(m_rd_req), .m_rd_type(m_rd_type), .m_rd_addr(m_rd_addr), .m_rd_rdy(m_rd_rdy),
    .m_ret_valid(m_ret_valid), .m_ret_last(m_ret_last), .m_ret_data(m_ret_data),
    .m_wr_req(m_wr_req), .m_wr_type(m_wr_type), .m_wr_addr(m_wr_addr),
    .m_wr_wstrb(m_wr_wstrb), .m_wr_data(m_wr_data), .m_wr_rdy(m_wr_rdy)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input bit to_i, input logic [2:0] typ, input logic [31:0] addr);
    if (to_i) begin
      i_rd_req = 1'b1; i_rd_type = typ; i_rd_addr = addr;
    end else begin
      d_rd_req = 1'b1; d_rd_type = typ; d_rd_addr = addr;
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " i_rd_rdy"}, 64'(i_rd_rdy), 64'd0);
    checkOutput({tag, " d_rd_rdy"}, 64'(d_rd_rdy), 64'd0);
    checkOutput({tag, " d_wr_rdy"}, 64'(d_wr_rdy), 64'd0);
    checkOutput({tag, " m_rd_req"}, 64'(m_rd_req), 64'd0);
    checkOutput({tag, " m_wr_req"}, 64'(m_wr_req), 64'd0);
    checkOutput({tag, " i_ret_valid"}, 64'(i_ret_valid), 64'd0);
    checkOutput({tag, " i_ret_last"}, 64'(i_ret_last), 64'd0);
    checkOutput({tag, " d_ret_valid"}, 64'(d_ret_valid), 64'd0);
    checkOutput({tag, " m_rd_addr"}, 64'(m_rd_addr), 64'd0);
    checkOutput({tag, " m_rd_type"}, 64'(m_rd_type), 64'd0);
    checkOutput({tag, " m_wr_addr"}, 64'(m_wr_addr), 64'd0);
    checkOutput({tag, " m_wr_wstrb"}, 64'(m_wr_wstrb), 64'd0);
    checkOutput({tag, " m_wr_data"}, m_wr_data[63:0] | m_wr_data[127:64], 64'd0);
  endtask

  // Acts as the bridge: accept the pending read, then return beats.
  task automatic serve_read(input bit to_i, input int n, input int total, input logic [31:0] base);
    beat_t e;
    for (int k = 0; k < 20 && !m_rd_req; k++) tick();
    checks++;
    if (!m_rd_req) begin
      errors++;
      $display("[TB] FAIL m_rd_req timeout: got 0 expected 1");
      return;
    end
    m_rd_rdy = 1'b1;
    tick();
    m_rd_rdy = 1'b0;
    for (int b = 0; b < n; b++) begin
      m_ret_valid = 1'b1;
      m_ret_data  = base + 32'(b);
      m_ret_last  = (b == total - 1);
      e.data = m_ret_data;
      e.last = m_ret_last;
      if (to_i) exp_i.push_back(e);
      else      exp_d.push_back(e);
      tick();
    end
    m_ret_valid = 1'b0;
    m_ret_last  = 1'b0;
    m_ret_data  = '0;
  endtask

  always @(negedge clock) begin
    beat_t e;
    logic [34:0] r;
    logic [166:0] w;
    if (i_ret_valid) begin
      checks++;
      if (exp_i.size() == 0) begin
        errors++;
        $display("[TB] FAIL i_ret unexpected: got %h expected none", i_ret_data);
      end else begin
        e = exp_i.pop_front();
        if ({i_ret_data, i_ret_last} !== e) begin
          errors++;
          $display("[TB] FAIL i_ret beat: got %h/%b expected %h/%b", i_ret_data, i_ret_last, e.data, e.last);
        end
      end
    end
    if (d_ret_valid) begin
      checks++;
      if (exp_d.size() == 0) begin
        errors++;
        $display("[TB] FAIL d_ret unexpected: got %h expected none", d_ret_data);
      end else begin
        e = exp_d.pop_front();
        if ({d_ret_data, d_ret_last} !== e) begin
          errors++;
          $display("[TB] FAIL d_ret beat: got %h/%b expected %h/%b", d_ret_data, d_ret_last, e.data, e.last);
        end
      end
    end
    if (m_rd_req && m_rd_rdy) begin
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("[TB] FAIL m_rd unexpected: got %h expected none", {m_rd_type, m_rd_addr});
      end else begin
        r = exp_rd.pop_front();
        if ({m_rd_type, m_rd_addr} !== r) begin
          errors++;
          $display("[TB] FAIL m_rd request: got %h expected %h", {m_rd_type, m_rd_addr}, r);
        end
      end
    end
    if (m_wr_req && m_wr_rdy) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("[TB] FAIL m_wr unexpected: got %h expected none", m_wr_addr);
      end else begin
        w = exp_wr.pop_front();
        if ({m_wr_type, m_wr_addr, m_wr_wstrb, m_wr_data} !== w) begin
          errors++;
          $display("[TB] FAIL m_wr request: got %h expected %h", {m_wr_type, m_wr_addr, m_wr_wstrb, m_wr_data}, w);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset held with requests asserted: nothing may be accepted.
    i_rd_req = 1; d_rd_req = 1; d_wr_req = 1;
    tick(); tick();
    checkResetOutputs("reset");
    i_rd_req = 0; d_rd_req = 0; d_wr_req = 0;
    resetn = 1'b1;
    tick(); tick();

    // Tie from reset: I, then D, then I.
    applyStimulus(1, RD_TYPE_WORD, 32'h400);
    applyStimulus(0, RD_TYPE_WORD, 32'h500);
    #1;
    checkOutput("tie1 i_rd_rdy", 64'(i_rd_rdy), 64'd1);
    checkOutput("tie1 d_rd_rdy", 64'(d_rd_rdy), 64'd0);
    exp_rd.push_back({RD_TYPE_WORD, 32'h400});
    tick();
    checkOutput("tie1 m_rd_req", 64'(m_rd_req), 64'd1);
    checkOutput("req d_rd_rdy", 64'(d_rd_rdy), 64'd0);
    serve_read(1, 1, 1, 32'h1111_0000);
    #1;
    checkOutput("tie2 d_rd_rdy", 64'(d_rd_rdy), 64'd1);
    checkOutput("tie2 i_rd_rdy", 64'(i_rd_rdy), 64'd0);
    exp_rd.push_back({RD_TYPE_WORD, 32'h500});
    tick();
    serve_read(0, 1, 1, 32'h2222_0000);
    #1;
    checkOutput("tie3 i_rd_rdy", 64'(i_rd_rdy), 64'd1);
    checkOutput("tie3 d_rd_rdy", 64'(d_rd_rdy), 64'd0);
    exp_rd.push_back({RD_TYPE_WORD, 32'h400});
    tick();
    i_rd_req = 0; d_rd_req = 0;
    serve_read(1, 1, 1, 32'h3333_0000);

    // Uncached D word read, then I line read in the very next cycle.
    applyStimulus(0, RD_TYPE_WORD, 32'h1000);
    #1;
    checkOutput("word d_rd_rdy", 64'(d_rd_rdy), 64'd1);
    exp_rd.push_back({RD_TYPE_WORD, 32'h1000});
    tick();
    d_rd_req = 0;
    serve_read(0, 1, 1, 32'hDEAD_BEEF);
    applyStimulus(1, RD_TYPE_LINE, 32'h100);
    #1;
    checkOutput("line i_rd_rdy c0", 64'(i_rd_rdy), 64'd1);
    exp_rd.push_back({RD_TYPE_LINE, 32'h100});
    tick();
    i_rd_req = 0;
    checkOutput("line m_rd_req c1", 64'(m_rd_req), 64'd1);
    checkOutput("line m_rd_addr", 64'(m_rd_addr), 64'h100);
    checkOutput("line m_rd_type", 64'(m_rd_type), 64'(RD_TYPE_LINE));
    serve_read(1, 4, 4, 32'hA0);

    // Write buffered and stalled; same-line D read blocked, other line granted.
    d_wr_req = 1; d_wr_type = RD_TYPE_LINE; d_wr_addr = 32'h200; d_wr_wstrb = 4'hF;
    d_wr_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    #1;
    checkOutput("wr d_wr_rdy", 64'(d_wr_rdy), 64'd1);
    exp_wr.push_back({RD_TYPE_LINE, 32'h200, 4'hF, d_wr_data});
    tick();
    d_wr_req = 0;
    checkOutput("wr m_wr_req", 64'(m_wr_req), 64'd1);
    checkOutput("wr full d_wr_rdy", 64'(d_wr_rdy), 64'd0);
    applyStimulus(0, RD_TYPE_WORD, 32'h208);
    #1;
    checkOutput("hazard d_rd_rdy", 64'(d_rd_rdy), 64'd0);
    tick();
    checkOutput("hazard hold d_rd_rdy", 64'(d_rd_rdy), 64'd0);
    checkOutput("hazard m_rd_req", 64'(m_rd_req), 64'd0);
    d_rd_addr = 32'h300;
    #1;
    checkOutput("other line d_rd_rdy", 64'(d_rd_rdy), 64'd1);
    exp_rd.push_back({RD_TYPE_WORD, 32'h300});
    tick();
    d_rd_req = 0;
    serve_read(0, 1, 1, 32'h3000_0001);
    checkOutput("wr still m_wr_req", 64'(m_wr_req), 64'd1);
    applyStimulus(0, RD_TYPE_WORD, 32'h208);
    #1;
    checkOutput("hazard2 d_rd_rdy", 64'(d_rd_rdy), 64'd0);
    m_wr_rdy = 1'b1;
    tick();
    m_wr_rdy = 1'b0;
    checkOutput("drained m_wr_req", 64'(m_wr_req), 64'd0);
    checkOutput("released d_rd_rdy", 64'(d_rd_rdy), 64'd1);
    exp_rd.push_back({RD_TYPE_WORD, 32'h208});
    tick();
    d_rd_req = 0;
    serve_read(0, 1, 1, 32'h2080_0001);

    // Reset in WAIT after 2 of 4 beats with a write still buffered.
    d_wr_req = 1; d_wr_addr = 32'h700;
    tick();
    d_wr_req = 0;
    checkOutput("abort wb m_wr_req", 64'(m_wr_req), 64'd1);
    applyStimulus(1, RD_TYPE_LINE, 32'h600);
    #1;
    checkOutput("abort i_rd_rdy", 64'(i_rd_rdy), 64'd1);
    exp_rd.push_back({RD_TYPE_LINE, 32'h600});
    tick();
    i_rd_req = 0;
    serve_read(1, 2, 4, 32'hB0);
    m_ret_valid = 1; m_ret_data = 32'hB2; i_rd_req = 1; d_wr_req = 1;
    resetn = 1'b0;
    #1;
    checkResetOutputs("abort");
    tick();
    m_ret_valid = 0; m_ret_data = 0; i_rd_req = 0; d_wr_req = 0;
    resetn = 1'b1;
    tick(); tick();
    applyStimulus(1, RD_TYPE_WORD, 32'h800);
    #1;
    checkOutput("post-reset i_rd_rdy", 64'(i_rd_rdy), 64'd1);
    exp_rd.push_back({RD_TYPE_WORD, 32'h800});
    tick();
    i_rd_req = 0;
    serve_read(1, 1, 1, 32'hC0);

    tick(); tick();
    checkOutput("exp_i drained", 64'(exp_i.size()), 64'd0);
    checkOutput("exp_d drained", 64'(exp_d.size()), 64'd0);
    checkOutput("exp_rd drained", 64'(exp_rd.size()), 64'd0);
    checkOutput("exp_wr drained", 64'(exp_wr.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
